cobs_decoder: RTL and testbench

//  Receive-side COBS decoder: consumes 0x00-delimited COBS frames on an AXI-Stream byte input.

---
 rtl/cobs_pkg.sv | 10 +
 rtl/cobs_out_reg.sv | 58 +++++
 rtl/cobs_decoder.sv | 137 +++++++++++++
 tb/tb_cobs_decoder.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cobs_pkg.sv
// Shared COBS constants and the decoder state type, used by both the encoder and decoder paths.
package cobs_pkg;
  localparam logic [7:0] COBS_DELIM    = 8'h00;
  localparam logic [7:0] COBS_MAX_CODE = 8'hFF;

  typedef enum logic {
    WAIT_CODE = 1'b0,
    IN_BLOCK  = 1'b1
  } cobs_dec_state_t;
endpackage

// File: rtl/cobs_out_reg.sv
// One-byte hold stage plus registered AXIS output; a byte leaves hold once its successor or the frame end is known.
// Loads happen only on accepted input, which the top gates with !o_vld || i_rdy, so the output never overruns.
module cobs_out_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic [7:0] i_push_dat,
  input  logic       i_end,
  input  logic       i_end_err,
  input  logic       i_rdy,
  output logic [7:0] o_dat,
  output logic       o_vld,
  output logic       o_last,
  output logic       o_user
);
  logic       r_hold_vld;
  logic [7:0] r_hold_dat;
  logic [7:0] r_dat;
  logic       r_vld;
  logic       r_last;
  logic       r_user;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold_vld <= 1'b0;
      r_hold_dat <= 8'h00;
      r_dat      <= 8'h00;
      r_vld      <= 1'b0;
      r_last     <= 1'b0;
      r_user     <= 1'b0;
    end else begin
      if (r_vld && i_rdy) begin
        r_vld <= 1'b0;
      end
      if (i_push) begin
        if (r_hold_vld) begin
          r_dat  <= r_hold_dat;
          r_vld  <= 1'b1;
          r_last <= 1'b0;
          r_user <= 1'b0;
        end
        r_hold_dat <= i_push_dat;
        r_hold_vld <= 1'b1;
      end else if (i_end && r_hold_vld) begin
        r_dat      <= r_hold_dat;
        r_vld      <= 1'b1;
        r_last     <= 1'b1;
        r_user     <= i_end_err;
        r_hold_vld <= 1'b0;
      end
    end
  end

  assign o_dat  = r_dat;
  assign o_vld  = r_vld;
  assign o_last = r_last;
  assign o_user = r_user;
endmodule

// File: rtl/cobs_decoder.sv
// Receive-side COBS decoder: 0x00-delimited frames in, payload bytes out with tlast/tuser; one-byte hold latency.
// Input ready follows output free (!m_axis_tvalid || m_axis_tready); truncated frames pulse frame_err and bump err_count.
module cobs_decoder
  import cobs_pkg::*;
#(
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [7:0]               m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tuser,
  output logic                     frame_err,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);
  cobs_dec_state_t          r_state;
  cobs_dec_state_t          w_state_nxt;
  logic [7:0]               r_remaining;
  logic                     r_pending_zero;
  logic                     r_frame_err;
  logic [ERR_CNT_WIDTH-1:0] r_err_count;

  logic       w_accept;
  logic       w_is_delim;
  logic       w_push;
  logic [7:0] w_push_dat;
  logic       w_end;
  logic       w_err;

  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign w_accept      = s_axis_tvalid && s_axis_tready;
  assign w_is_delim    = (s_axis_tdata == COBS_DELIM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= WAIT_CODE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      case (r_state)
        WAIT_CODE: begin
          if (!w_is_delim && (s_axis_tdata > 8'd1)) begin
            w_state_nxt = IN_BLOCK;
          end
        end
        IN_BLOCK: begin
          if (w_is_delim || (r_remaining == 8'd1)) begin
            w_state_nxt = WAIT_CODE;
          end
        end
        default: w_state_nxt = WAIT_CODE;
      endcase
    end
  end

  always_comb begin
    w_push     = 1'b0;
    w_push_dat = 8'h00;
    w_end      = 1'b0;
    w_err      = 1'b0;
    if (w_accept) begin
      case (r_state)
        WAIT_CODE: begin
          if (w_is_delim) begin
            w_end = 1'b1;
          end else if (r_pending_zero) begin
            w_push     = 1'b1;
            w_push_dat = COBS_DELIM;
          end
        end
        IN_BLOCK: begin
          if (w_is_delim) begin
            w_end = 1'b1;
            w_err = 1'b1;
          end else begin
            w_push     = 1'b1;
            w_push_dat = s_axis_tdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Block bookkeeping: a code of MAX_CODE carries no implied zero after its data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_remaining    <= 8'h00;
      r_pending_zero <= 1'b0;
      r_frame_err    <= 1'b0;
      r_err_count    <= '0;
    end else begin
      r_frame_err <= w_err;
      if (w_err && (r_err_count != {ERR_CNT_WIDTH{1'b1}})) begin
        r_err_count <= r_err_count + 1'b1;
      end
      if (w_accept) begin
        if (w_is_delim) begin
          r_pending_zero <= 1'b0;
          r_remaining    <= 8'h00;
        end else if (r_state == WAIT_CODE) begin
          r_remaining    <= s_axis_tdata - 8'd1;
          r_pending_zero <= (s_axis_tdata != COBS_MAX_CODE);
        end else begin
          r_remaining <= r_remaining - 8'd1;
        end
      end
    end
  end

  assign frame_err = r_frame_err;
  assign err_count = r_err_count;

  cobs_out_reg u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_end      (w_end),
    .i_end_err  (w_err),
    .i_rdy      (m_axis_tready),
    .o_dat      (m_axis_tdata),
    .o_vld      (m_axis_tvalid),
    .o_last     (m_axis_tlast),
    .o_user     (m_axis_tuser)
  );
endmodule

// File: tb/tb_cobs_decoder.sv
// Scoreboard bench for cobs_decoder: expected beats are queued as frames are sent and matched against observed beats.
module tb_cobs_decoder;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [7:0]    m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;
  logic          m_tuser;
  logic          frame_err;
  logic [EW-1:0] err_count;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  int    errors = 0;
  int    checks = 0;
  beat_t exp_q[$];
  beat_t obs_q[$];
  logic [7:0] tx_q[$];
  int    fe_pulses = 0;
  int    rdy_mode = 0;
  bit    gaps = 1'b0;
  bit    prev_stall = 1'b0;
  beat_t prev_beat;

  always #5 clk = ~clk;

  cobs_decoder #(.ERR_CNT_WIDTH(EW)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser),
    .frame_err     (frame_err),
    .err_count     (err_count)
  );

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       m_tready = 1'($urandom_range(0, 1));
      2:       m_tready = 1'b0;
      default: m_tready = 1'b1;
    endcase
  end

  // Monitor: collect transferred beats, count error pulses, and check output stability under stall.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && m_tvalid) begin
        checks++;
        if ({m_tdata, m_tlast, m_tuser} !== prev_beat) begin
          errors++;
          $display("FAIL stall_stable got=%h exp=%h", {m_tdata, m_tlast, m_tuser}, prev_beat);
        end
      end
      if (m_tvalid && m_tready) obs_q.push_back(beat_t'({m_tdata, m_tlast, m_tuser}));
      if (frame_err) fe_pulses++;
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = beat_t'({m_tdata, m_tlast, m_tuser});
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit acc;
    bit done;
    int n;
    if (gaps) begin
      n = $urandom_range(0, 2);
      repeat (n) begin
        @(posedge clk);
        #1;
      end
    end
    s_tdata  = b;
    s_tvalid = 1'b1;
    done     = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1;
      if (acc) done = 1'b1;
    end
    s_tvalid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL input_accept_timeout byte=%h not accepted within 200 cycles", b);
    end
  endtask

  task automatic send_all();
    while (tx_q.size() > 0) send_byte(tx_q.pop_front());
  endtask

  task automatic push_exp(input logic [7:0] d, input logic l, input logic u);
    exp_q.push_back(beat_t'({d, l, u}));
  endtask

  task automatic wait_out(output bit ok);
    for (int t = 0; t < 3000 && obs_q.size() < exp_q.size(); t++) @(negedge clk);
    repeat (6) @(negedge clk);
    ok = (obs_q.size() == exp_q.size());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b exp=0", m_tvalid); end
    checks++; if (m_tdata !== 8'h00) begin errors++; $display("FAIL reset_tdata got=%h exp=00", m_tdata); end
    checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got=%b exp=0", m_tlast); end
    checks++; if (m_tuser !== 1'b0) begin errors++; $display("FAIL reset_tuser got=%b exp=0", m_tuser); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    checks++; if (err_count !== '0) begin errors++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL reset_tready got=%b exp=1", s_tready); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    bit ok;
    beat_t e, o;
    tx_q = '{8'h03, 8'h69, 8'h70, 8'h00};
    push_exp(8'h69, 1'b0, 1'b0);
    push_exp(8'h70, 1'b1, 1'b0);
    send_all();
    wait_out(ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL basic_beat got=%h exp=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_empty_frames();
    bit ok;
    beat_t e, o;
    int fe0;
    fe0 = fe_pulses;
    tx_q = '{8'h01, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    push_exp(8'h00, 1'b1, 1'b0);
    send_all();
    wait_out(ok);
    checks++; if (!ok) begin errors++; $display("FAIL empty_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL empty_beat got=%h exp=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    checks++; if (err_count !== '0) begin errors++; $display("FAIL empty_err_count got=%0d exp=0", err_count); end
    checks++; if (fe_pulses != fe0) begin errors++; $display("FAIL empty_frame_err got=%0d exp=0", fe_pulses - fe0); end
  endtask

  task automatic test_zeros(input bit stress, input int reps);
    bit ok;
    beat_t e, o;
    gaps     = stress;
    rdy_mode = stress ? 1 : 0;
    for (int r = 0; r < reps; r++) begin
      tx_q.push_back(8'h02); tx_q.push_back(8'h11); tx_q.push_back(8'h01);
      tx_q.push_back(8'h01); tx_q.push_back(8'h00);
      push_exp(8'h11, 1'b0, 1'b0);
      push_exp(8'h00, 1'b0, 1'b0);
      push_exp(8'h00, 1'b1, 1'b0);
    end
    send_all();
    wait_out(ok);
    checks++; if (!ok) begin errors++; $display("FAIL zeros_count stress=%0d got=%0d exp=%0d", stress, obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL zeros_beat stress=%0d got=%h exp=%h", stress, o, e); end
    end
    exp_q.delete(); obs_q.delete();
    gaps     = 1'b0;
    rdy_mode = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_max_block();
    bit ok;
    beat_t e, o;
    tx_q.push_back(8'hFF);
    for (int i = 1; i <= 254; i++) begin
      tx_q.push_back(8'(i));
      push_exp(8'(i), (i == 254), 1'b0);
    end
    tx_q.push_back(8'h00);
    send_all();
    wait_out(ok);
    checks++; if (!ok) begin errors++; $display("FAIL max_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL max_beat got=%h exp=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_truncated();
    bit ok;
    beat_t e, o;
    int fe0;
    fe0 = fe_pulses;
    tx_q = '{8'h04, 8'hAA, 8'hBB, 8'h00, 8'h02, 8'hCC, 8'h00};
    push_exp(8'hAA, 1'b0, 1'b0);
    push_exp(8'hBB, 1'b1, 1'b1);
    push_exp(8'hCC, 1'b1, 1'b0);
    send_all();
    wait_out(ok);
    checks++; if (!ok) begin errors++; $display("FAIL trunc_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL trunc_beat got=%h exp=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    checks++; if (fe_pulses != fe0 + 1) begin errors++; $display("FAIL trunc_frame_err got=%0d exp=1", fe_pulses - fe0); end
    checks++; if (err_count !== 2'd1) begin errors++; $display("FAIL trunc_err_count got=%0d exp=1", err_count); end
  endtask

  task automatic test_saturation();
    bit ok;
    int fe0;
    fe0 = fe_pulses;
    for (int i = 0; i < 4; i++) begin
      tx_q.push_back(8'h02);
      tx_q.push_back(8'h00);
    end
    send_all();
    wait_out(ok);
    checks++; if (!ok) begin errors++; $display("FAIL sat_no_beats got=%0d exp=0", obs_q.size()); end
    obs_q.delete();
    checks++; if (fe_pulses != fe0 + 4) begin errors++; $display("FAIL sat_frame_err got=%0d exp=4", fe_pulses - fe0); end
    checks++; if (err_count !== 2'd3) begin errors++; $display("FAIL sat_err_count got=%0d exp=3", err_count); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    beat_t e, o;
    rdy_mode = 2;
    @(posedge clk);
    #1;
    tx_q = '{8'h03, 8'h69, 8'h70};
    send_all();
    @(negedge clk);
    checks++; if (m_tvalid !== 1'b1 || m_tdata !== 8'h69) begin errors++; $display("FAIL mid_stalled_beat got=%b/%h exp=1/69", m_tvalid, m_tdata); end
    #1;
    rst = 1'b0;
    #1;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_tvalid got=%b exp=0", m_tvalid); end
    checks++; if (m_tdata !== 8'h00) begin errors++; $display("FAIL mid_rst_tdata got=%h exp=00", m_tdata); end
    checks++; if (err_count !== '0) begin errors++; $display("FAIL mid_rst_err_count got=%0d exp=0", err_count); end
    rdy_mode = 0;
    obs_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    tx_q = '{8'h02, 8'hCC, 8'h00};
    push_exp(8'hCC, 1'b1, 1'b0);
    send_all();
    wait_out(ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL mid_beat got=%h exp=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty_frames();
    test_zeros(1'b0, 1);
    test_max_block();
    test_truncated();
    test_saturation();
    test_zeros(1'b1, 6);
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
